apb_master_mux: RTL and testbench

//  Parametrised APB master. Converts single-shot user requests (newd/wr/Addr/datain)

---
 rtl/apb_master_mux.sv | 172 +++++++++++++++++
 tb/tb_apb_master_mux.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/apb_master_mux.sv
// APB master: turns single-shot user requests into SETUP/ACCESS transfers to one of NUM_SLV slaves.
// Optional `APB_TIMEOUT_EN adds an ACCESS wait-cycle limit (TIMEOUT_CYC) that aborts with err=1.
module apb_master_mux #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int NUM_SLV     = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      Pclk,
  input  logic                      Presetn,
  input  logic                      newd,
  input  logic                      wr,
  input  logic [ADDR_W-1:0]         Addr,
  input  logic [DATA_W-1:0]         datain,
  output logic [DATA_W-1:0]         dataout,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [NUM_SLV-1:0]        Psel,
  output logic                      Penable,
  output logic [ADDR_W-1:0]         Paddr,
  output logic [DATA_W-1:0]         PWdata,
  output logic                      Pwrite,
  input  logic [NUM_SLV*DATA_W-1:0] PRdata,
  input  logic [NUM_SLV-1:0]        Pready,
  input  logic [NUM_SLV-1:0]        Pslverr,
  output logic [1:0]                state_dbg
);

  localparam int SLV_BITS = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [SLV_BITS:0] NUM_SLV_W = (SLV_BITS+1)'(NUM_SLV);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t state, state_n;
  logic [SLV_BITS-1:0] idx_q, idx_n;
  logic [NUM_SLV-1:0]  psel_n;
  logic                penable_n, pwrite_n, done_n, err_n;
  logic [ADDR_W-1:0]   paddr_n;
  logic [DATA_W-1:0]   pwdata_n, dataout_n;

  // Request handshake: newd is a one-cycle strobe taken only when state is IDLE
  // and no done pulse is showing; otherwise it is dropped, never queued.
  logic [SLV_BITS-1:0] req_idx;
  logic                req_valid;
  assign req_idx   = Addr[ADDR_W-1 -: SLV_BITS];
  assign req_valid = ({1'b0, req_idx} < NUM_SLV_W);

  logic              sel_ready, sel_err;
  logic [DATA_W-1:0] sel_rdata;
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == SLV_BITS'(i)) begin
        sel_ready = Pready[i];
        sel_err   = Pslverr[i];
        sel_rdata = PRdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
  logic             timed_out;
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYC));
`endif

  always_comb begin
    state_n   = state;
    idx_n     = idx_q;
    psel_n    = Psel;
    penable_n = Penable;
    paddr_n   = Paddr;
    pwdata_n  = PWdata;
    pwrite_n  = Pwrite;
    dataout_n = dataout;
    done_n    = 1'b0;
    err_n     = 1'b0;
`ifdef APB_TIMEOUT_EN
    wait_cnt_n = wait_cnt;
`endif
    case (state)
      IDLE: begin
        if (newd && !done) begin
          paddr_n  = Addr;
          pwdata_n = datain;
          pwrite_n = wr;
          if (req_valid) begin
            idx_n   = req_idx;
            state_n = SETUP;
            for (int i = 0; i < NUM_SLV; i++) psel_n[i] = (req_idx == SLV_BITS'(i));
          end else begin
            done_n = 1'b1;
            err_n  = 1'b1;
          end
        end
      end
      SETUP: begin
        state_n   = ACCESS;
        penable_n = 1'b1;
`ifdef APB_TIMEOUT_EN
        wait_cnt_n = '0;
`endif
      end
      ACCESS: begin
`ifdef APB_TIMEOUT_EN
        if (timed_out) begin
          state_n   = IDLE;
          psel_n    = '0;
          penable_n = 1'b0;
          done_n    = 1'b1;
          err_n     = 1'b1;
        end else
`endif
        if (sel_ready) begin
          state_n   = IDLE;
          psel_n    = '0;
          penable_n = 1'b0;
          done_n    = 1'b1;
          err_n     = sel_err;
          if (!Pwrite && !sel_err) dataout_n = sel_rdata;
        end else begin
`ifdef APB_TIMEOUT_EN
          wait_cnt_n = wait_cnt + 1'b1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      state   <= IDLE;
      idx_q   <= '0;
      Psel    <= '0;
      Penable <= 1'b0;
      Paddr   <= '0;
      PWdata  <= '0;
      Pwrite  <= 1'b0;
      dataout <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      idx_q   <= idx_n;
      Psel    <= psel_n;
      Penable <= penable_n;
      Paddr   <= paddr_n;
      PWdata  <= pwdata_n;
      Pwrite  <= pwrite_n;
      dataout <= dataout_n;
      done    <= done_n;
      err     <= err_n;
      busy    <= (state_n != IDLE);
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) wait_cnt <= '0;
    else          wait_cnt <= wait_cnt_n;
  end
`endif

  assign state_dbg = state;

endmodule

// File: tb/tb_apb_master_mux.sv
// Self-checking bench for apb_master_mux with NUM_SLV=3 so the top index value is a decode error.
// Completion status/data are predicted at request time and compared when done pulses.
module tb_apb_master_mux;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int NSLV   = 3;
  localparam int TO     = 4;

  logic              Pclk = 1'b0;
  logic              Presetn;
  logic              newd, wr;
  logic [7:0]        Addr, datain, dataout, Paddr, PWdata;
  logic              busy, done, err, Penable, Pwrite;
  logic [NSLV-1:0]   Psel, Pready, Pslverr;
  logic [NSLV*8-1:0] PRdata;
  logic [1:0]        state_dbg;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  logic [7:0] model_dout = 8'h00;

  always #5 Pclk = ~Pclk;

  apb_master_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NSLV), .TIMEOUT_CYC(TO)) dut (
    .Pclk(Pclk), .Presetn(Presetn), .newd(newd), .wr(wr), .Addr(Addr), .datain(datain),
    .dataout(dataout), .busy(busy), .done(done), .err(err), .Psel(Psel), .Penable(Penable),
    .Paddr(Paddr), .PWdata(PWdata), .Pwrite(Pwrite), .PRdata(PRdata), .Pready(Pready),
    .Pslverr(Pslverr), .state_dbg(state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest prediction.
  always @(negedge Pclk) begin
    if (Presetn === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_err", err, mon_e[8]);
        check("sb_dataout", dataout, mon_e[7:0]);
      end
    end
  end

  task automatic do_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                        input int waits, input logic serr, input logic [7:0] rd, input bit poke);
    logic [1:0] idx;
    bit         valid;
    logic       e;
    idx   = a[7:6];
    valid = (idx < NSLV);
    e     = !valid || serr;
    Pready  = '1;
    Pslverr = '1;
    PRdata  = 24'($urandom);
    if (valid) begin
      Pready[idx]         = (waits == 0);
      Pslverr[idx]        = serr;
      PRdata[idx*8 +: 8]  = rd;
    end
    if (!w && !e) model_dout = rd;
    exp_q.push_back({e, model_dout});
    @(negedge Pclk);
    newd = 1'b1; wr = w; Addr = a; datain = d;
    @(negedge Pclk);
    newd = 1'b0; wr = ~w; Addr = 8'($urandom); datain = 8'($urandom);
    if (!valid) begin
      check("dec_done", done, 1);
      check("dec_psel", Psel, 0);
      check("dec_busy", busy, 0);
      check("dec_paddr", Paddr, a);
      if (poke) begin
        newd = 1'b1; Addr = 8'h05;
      end
    end else begin
      check("setup_psel", Psel, 3'b001 << idx);
      check("setup_pen", Penable, 0);
      check("setup_busy", busy, 1);
      check("setup_paddr", Paddr, a);
      check("setup_pwdata", PWdata, d);
      check("setup_pwrite", Pwrite, w);
      if (poke) begin
        newd = 1'b1; Addr = 8'h45;
      end
      @(negedge Pclk);
      newd = 1'b0;
      for (int n = 0; n <= waits; n++) begin
        check("acc_pen", Penable, 1);
        check("acc_psel", Psel, 3'b001 << idx);
        check("acc_pwdata", PWdata, d);
        check("acc_done", done, 0);
        Pready[idx] = (n == waits);
        @(negedge Pclk);
      end
      check("cmp_done", done, 1);
      check("cmp_psel", Psel, 0);
      check("cmp_pen", Penable, 0);
      check("cmp_busy", busy, 0);
      if (poke) begin
        newd = 1'b1; Addr = 8'h05;
      end
    end
    @(negedge Pclk);
    newd = 1'b0;
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("idle_paddr", Paddr, a);
    check("idle_pwrite", Pwrite, w);
  endtask

  task automatic stuck_start(input logic [7:0] a);
    Pready  = '0;
    Pslverr = '0;
    @(negedge Pclk);
    newd = 1'b1; wr = 1'b0; Addr = a;
    @(negedge Pclk);
    newd = 1'b0;
    @(negedge Pclk);
  endtask

  initial begin
    int lat;
    Presetn = 1'b0; newd = 1'b0; wr = 1'b0; Addr = '0; datain = '0;
    Pready = '1; Pslverr = '0; PRdata = '0;
    repeat (2) @(negedge Pclk);
    check("rst_outputs", {dataout, Psel, Penable, Paddr, PWdata, Pwrite, busy, done, err}, 0);
    Presetn = 1'b1;
    @(negedge Pclk);

    do_req(1'b1, 8'h05, 8'hA5, 0, 1'b0, 8'h00, 1'b0);
    do_req(1'b0, 8'h85, 8'h00, 2, 1'b0, 8'h3C, 1'b0);
    do_req(1'b0, 8'h45, 8'h00, 0, 1'b1, 8'hFF, 1'b0);
    check("dataout_kept", dataout, 8'h3C);
    do_req(1'b0, 8'hC0, 8'h00, 0, 1'b0, 8'h77, 1'b1);
    do_req(1'b1, 8'h8A, 8'h5A, 1, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 8; k++) begin
      logic [7:0] ra;
      ra = {2'($urandom_range(0, 3)), 6'($urandom)};
      do_req(1'($urandom), ra, 8'($urandom), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom));
    end

`ifdef APB_TIMEOUT_EN
    exp_q.push_back({1'b1, model_dout});
    stuck_start(8'h10);
    lat = 2;
    while (done !== 1'b1 && lat < 60) begin
      @(negedge Pclk);
      lat++;
    end
    check("to_latency", lat, 3 + TO);
    check("to_psel", Psel, 0);
    check("to_pen", Penable, 0);
    @(negedge Pclk);
    stuck_start(8'h10);
    @(negedge Pclk);
`else
    stuck_start(8'h10);
    repeat (100) @(negedge Pclk);
    check("hang_busy", busy, 1);
    check("hang_pen", Penable, 1);
    check("hang_psel", Psel, 3'b001);
`endif
    #2 Presetn = 1'b0;
    #1 check("midrst_outputs", {dataout, Psel, Penable, Paddr, PWdata, Pwrite, busy, done, err}, 0);
    model_dout = 8'h00;
    @(negedge Pclk);
    Presetn = 1'b1;
    Pready = '1;
    repeat (3) begin
      @(negedge Pclk);
      check("postrst_busy", busy, 0);
      check("postrst_done", done, 0);
    end
    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
